egress_rr_drain: RTL and testbench
==================================

EGRESS_RR_DRAIN -- requirements
Module: egress_rr_drain

Interface
REQ-001 The block SHALL have parameter TAMANO_DATOS, default 12: word width of every data port.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port empty, input, 4: empty flags of the four output FIFOs; bit N belongs to FIFO N.
REQ-005 The block SHALL have ports data_in0..data_in3, input, TAMANO_DATOS each: data_out of output FIFOs 0..3.
REQ-006 The block SHALL have port pop, output, 4: read_enable to FIFOs 0..3, with at most one bit high per cycle.
REQ-007 The block SHALL have port data_out, output, TAMANO_DATOS: egress word.
REQ-008 The block SHALL have port valid_out, output, 1: data_out holds a valid word.
REQ-009 The block SHALL have port ready_in, input, 1: sink accepts a word this cycle.
REQ-010 The block SHALL have port idle, output, 1: FSM is in IDLE.
REQ-011 The block SHALL have port cnt, output, 20: four 5-bit per-port delivered-word counters; cnt[5N+4:5N] belongs to port N.

Function
REQ-012 FIFO read latency SHALL be 1 cycle: when pop[N]=1 in cycle t, data_inN is valid in cycle t+1.
REQ-013 The block SHALL capture the valid word from the port popped in cycle t into the skid buffer at the clock edge that ends cycle t+1.
REQ-014 The block SHALL use a 2-entry in-order skid buffer whose head drives data_out and valid_out.
REQ-015 A word SHALL be delivered only in a cycle where valid_out=1 and ready_in=1; the head then advances.
REQ-016 While valid_out=1 and ready_in=0, data_out and valid_out SHALL hold stable.
REQ-017 A pop SHALL be issued only when (buffer occupancy + in-flight reads − delivery this cycle) < 2; the buffer never overflows.
REQ-018 A port SHALL be eligible only while its empty bit is 0 in the current cycle.
REQ-019 Grant SHALL be round-robin: the search starts at the port after the last granted port and wraps 3→0.
REQ-020 Ports with no grant SHALL be skipped without spending a cycle.
REQ-021 A capture and a delivery in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-022 Throughput: with ready_in=1 continuously and eligible ports available, the block SHALL deliver one word per cycle.
REQ-023 Latency: the first word SHALL appear on valid_out 2 cycles after its pop.
REQ-024 The block SHALL increment counter N by 1 when a word from port N is captured; the counter wraps 31→0.
REQ-025 FSM states SHALL be IDLE and ACTIVE.
REQ-026 IDLE→ACTIVE SHALL occur when any empty bit is 0.
REQ-027 ACTIVE→IDLE SHALL occur when empty=4'b1111, the buffer is empty, no read is in flight, and valid_out=0.
REQ-028 pop SHALL be 0 in IDLE.
REQ-029 The block SHALL NOT depend on the word contents; data passes unmodified.

Reset
REQ-030 While reset=1, the block SHALL drive pop=0, valid_out=0, data_out=0, cnt=0, idle=1, state IDLE, and the round-robin pointer to last-granted=3, so port 0 is checked first.
REQ-031 Reset mid-operation SHALL discard buffered and in-flight words; data_in arriving the cycle after reset SHALL be ignored.

Verification
REQ-032 Reset, then all FIFOs stay empty for 10 cycles -> pop=0, valid_out=0, idle=1, cnt=0 throughout.
REQ-033 FIFO2 holds words 12'hA01, 12'hA02; ready_in=1 -> pop[2] in cycles t and t+1; data_out=A01 in cycle t+2 and A02 in t+3; cnt[14:10]=2; idle returns to 1.
REQ-034 All four FIFOs hold 2 words each; ready_in=1 -> pop order is 0,1,2,3,0,1,2,3, one per cycle; 8 words delivered in that order; each counter=2.
REQ-035 Backpressure: ready_in=0 while FIFO1 has 5 words -> exactly 2 pops, then pop=0; data_out is stable with valid_out=1; releasing ready_in drains all 5 words in order with no loss or duplication.
REQ-036 Reset asserted one cycle after pop[0] -> the in-flight word is dropped, valid_out=0, cnt=0; after release, draining restarts at port 0.
REQ-037 Drive 33 words through port 3 -> cnt[19:15] wraps to 1.

Source files
------------

// File: rtl/egress_rr_drain.sv
// Round-robin drain of four output FIFOs into a single egress stream.
// Reads through a 2-entry skid buffer so the sink can stall without losing words.
module egress_rr_drain #(
  parameter int TAMANO_DATOS = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              empty,
  input  logic [TAMANO_DATOS-1:0] data_in0,
  input  logic [TAMANO_DATOS-1:0] data_in1,
  input  logic [TAMANO_DATOS-1:0] data_in2,
  input  logic [TAMANO_DATOS-1:0] data_in3,
  output logic [3:0]              pop,
  output logic [TAMANO_DATOS-1:0] data_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic                    idle,
  output logic [19:0]             cnt
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [TAMANO_DATOS-1:0] buf_r [2];
  logic [1:0]              occ_r;
  logic                    inflight_r;
  logic [1:0]              inflight_port_r;
  logic [1:0]              last_r;
  logic [4:0]              cnt_r [4];

  logic                    deliver_s;
  logic                    capture_s;
  logic [2:0]              load_s;
  logic                    space_s;
  logic                    grant_s;
  logic [1:0]              grant_port_s;
  logic [1:0]              cand_s;
  logic [1:0]              wr_idx_s;
  logic [3:0]              pop_s;
  logic [TAMANO_DATOS-1:0] cap_data_s;

  assign valid_out = (occ_r != 2'd0);
  assign data_out  = buf_r[0];
  assign idle      = (state_r == IDLE);
  assign cnt       = {cnt_r[3], cnt_r[2], cnt_r[1], cnt_r[0]};
  assign pop       = pop_s;

  assign deliver_s = valid_out & ready_in;
  assign capture_s = inflight_r;
  assign wr_idx_s  = occ_r - {1'b0, deliver_s};
  // Words that will sit in the buffer after this cycle if nothing new is popped.
  assign load_s    = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, deliver_s};
  assign space_s   = (load_s < 3'd2);

  // Round-robin search starting one past the last granted port.
  always_comb begin
    grant_s      = 1'b0;
    grant_port_s = 2'd0;
    cand_s       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand_s = last_r + 2'(k);
      if (!grant_s && !empty[cand_s]) begin
        grant_s      = 1'b1;
        grant_port_s = cand_s;
      end else begin
        grant_s      = grant_s;
      end
    end
  end

  // Pop issue: only in ACTIVE, with a winner and room for the returning word.
  always_comb begin
    pop_s = 4'b0000;
    if ((state_r == ACTIVE) && grant_s && space_s && !reset) begin
      pop_s[grant_port_s] = 1'b1;
    end else begin
      pop_s = 4'b0000;
    end
  end

  // Select the FIFO data bus of the port read last cycle.
  always_comb begin
    cap_data_s = data_in0;
    case (inflight_port_r)
      2'd0:    cap_data_s = data_in0;
      2'd1:    cap_data_s = data_in1;
      2'd2:    cap_data_s = data_in2;
      2'd3:    cap_data_s = data_in3;
      default: cap_data_s = data_in0;
    endcase
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (empty != 4'b1111) state_s = ACTIVE;
        else                  state_s = IDLE;
      end
      ACTIVE: begin
        if ((empty == 4'b1111) && (occ_r == 2'd0) && !inflight_r && !valid_out) state_s = IDLE;
        else                                                                     state_s = ACTIVE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, skid buffer, in-flight tracking and per-port counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      buf_r[0]        <= '0;
      buf_r[1]        <= '0;
      occ_r           <= 2'd0;
      inflight_r      <= 1'b0;
      inflight_port_r <= 2'd0;
      last_r          <= 2'd3;
      for (int n = 0; n < 4; n++) cnt_r[n] <= 5'd0;
    end else begin
      state_r    <= state_s;
      inflight_r <= (pop_s != 4'b0000);
      if (pop_s != 4'b0000) begin
        inflight_port_r <= grant_port_s;
        last_r          <= grant_port_s;
      end
      // Shift first; a same-cycle capture into slot 0 then overrides the shift.
      if (deliver_s) buf_r[0] <= buf_r[1];
      if (capture_s) begin
        buf_r[wr_idx_s[0]]       <= cap_data_s;
        cnt_r[inflight_port_r]   <= cnt_r[inflight_port_r] + 5'd1;
      end
      occ_r <= occ_r - {1'b0, deliver_s} + {1'b0, capture_s};
    end
  end

endmodule

// File: tb/tb_egress_rr_drain.sv
// Bench for egress_rr_drain: FIFO models, a word scoreboard and a round-robin
// reference drive directed scenarios followed by a randomized phase.
module tb_egress_rr_drain;
  localparam int TW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    empty = 4'hF;
  logic [TW-1:0] din [4];
  logic [3:0]    pop;
  logic [TW-1:0] data_out;
  logic          valid_out;
  logic          ready_in = 1'b0;
  logic          idle;
  logic [19:0]   cnt;

  egress_rr_drain #(.TAMANO_DATOS(TW)) dut (
    .clk(clk), .reset(reset), .empty(empty),
    .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
    .pop(pop), .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
    .idle(idle), .cnt(cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference state: FIFO contents, words captured but not yet delivered, counters.
  logic [TW-1:0] fq [4][$];
  logic [TW-1:0] exp_q [$];
  int            exp_cnt [4];
  int            last_port = 3;
  bit            pend = 1'b0;
  logic [TW-1:0] pend_word;
  int            pend_port = 0;
  bit            armed = 1'b0;
  bit            fresh = 1'b0;

  int            pop_log [$];
  int            pop_cyc [$];
  int            dcyc [$];
  logic [TW-1:0] dlog [$];

  logic          s_valid, s_idle;
  logic [TW-1:0] s_data;
  logic [19:0]   s_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int rr_expect();
    for (int k = 1; k <= 4; k++) begin
      int p;
      p = (last_port + k) % 4;
      if (fq[p].size() > 0) return p;
    end
    return -1;
  endfunction

  function automatic bit all_fifos_empty();
    for (int n = 0; n < 4; n++) if (fq[n].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void clear_logs();
    pop_log.delete(); pop_cyc.delete(); dcyc.delete(); dlog.delete();
  endfunction

  // One clock cycle: check outputs at the falling edge, advance the model after the rising edge.
  task automatic tick();
    logic [3:0]    pv;
    logic          vv, rv, rs;
    logic [TW-1:0] dv;
    int            gp;
    logic [TW-1:0] w;
    for (int n = 0; n < 4; n++) empty[n] = (fq[n].size() == 0);
    @(negedge clk);
    pv = pop; vv = valid_out; rv = ready_in; dv = data_out; rs = reset;
    s_valid = vv; s_idle = idle; s_data = dv; s_cnt = cnt;
    gp = -1;
    for (int n = 0; n < 4; n++) if (pv[n]) gp = n;
    if (rs) chk("pop_in_reset", 32'(pv), 32'd0);
    if (armed) begin
      chk("valid", 32'(vv), 32'(exp_q.size() != 0));
      if (vv && exp_q.size() > 0) chk("data", 32'(dv), 32'(exp_q[0]));
      if (fresh && !vv) chk("data_rst", 32'(dv), 32'd0);
      for (int n = 0; n < 4; n++) chk($sformatf("cnt%0d", n), 32'(cnt[5*n +: 5]), 32'(exp_cnt[n]));
      if (idle) chk("pop_idle", 32'(pv), 32'd0);
      if (pv != 4'b0000) begin
        chk("pop_onehot", 32'($countones(pv)), 32'd1);
        chk("rr_port", 32'(gp), 32'(rr_expect()));
        chk("space", 32'((exp_q.size() + int'(pend) - int'(vv & rv)) < 2), 32'd1);
        pop_log.push_back(gp);
        pop_cyc.push_back(cyc);
      end
      if (vv && rv && !rs) begin
        dlog.push_back(dv);
        dcyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rs) begin
      exp_q.delete();
      pend = 1'b0;
      for (int n = 0; n < 4; n++) exp_cnt[n] = 0;
      last_port = 3;
      fresh = 1'b1;
      armed = 1'b1;
    end else begin
      if (vv && rv && exp_q.size() > 0) void'(exp_q.pop_front());
      if (pend) begin
        exp_q.push_back(pend_word);
        exp_cnt[pend_port] = (exp_cnt[pend_port] + 1) % 32;
        fresh = 1'b0;
        pend = 1'b0;
      end
      if (gp >= 0 && fq[gp].size() > 0) begin
        w = fq[gp].pop_front();
        din[gp] = w;
        pend = 1'b1;
        pend_word = w;
        pend_port = gp;
        last_port = gp;
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    ready_in = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = all_fifos_empty() && (exp_q.size() == 0) && !pend && s_idle;
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    logic [TW-1:0] words [$];
    logic [TW-1:0] held;
    int            pushed;
    bit            ok;
    for (int n = 0; n < 4; n++) begin din[n] = '0; exp_cnt[n] = 0; end

    // Reset then ten idle cycles.
    do_reset(3);
    chk("rst_idle", 32'(s_idle), 32'd1);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_data", 32'(s_data), 32'd0);
    chk("rst_cnt", 32'(s_cnt), 32'd0);
    repeat (10) begin
      tick();
      chk("quiet_idle", 32'(s_idle), 32'd1);
    end

    // Two words through FIFO2.
    clear_logs();
    fq[2].push_back(12'hA01); fq[2].push_back(12'hA02);
    drain(30);
    chk("s2_pops", 32'(pop_log.size()), 32'd2);
    if (pop_log.size() == 2 && dlog.size() == 2) begin
      chk("s2_port0", 32'(pop_log[0]), 32'd2);
      chk("s2_port1", 32'(pop_log[1]), 32'd2);
      chk("s2_b2b", 32'(pop_cyc[1]), 32'(pop_cyc[0] + 1));
      chk("s2_lat0", 32'(dcyc[0]), 32'(pop_cyc[0] + 2));
      chk("s2_lat1", 32'(dcyc[1]), 32'(pop_cyc[0] + 3));
      chk("s2_w0", 32'(dlog[0]), 32'h0A01);
      chk("s2_w1", 32'(dlog[1]), 32'h0A02);
    end
    chk("s2_cnt2", 32'(s_cnt[14:10]), 32'd2);
    chk("s2_idle", 32'(s_idle), 32'd1);

    // All four FIFOs with two words: strict 0,1,2,3 rotation at full rate.
    do_reset(2);
    clear_logs();
    words.delete();
    for (int r = 0; r < 2; r++)
      for (int n = 0; n < 4; n++) begin
        fq[n].push_back(12'(16 * n + r + 12'h100));
        words.push_back(12'(16 * n + r + 12'h100));
      end
    drain(40);
    chk("s3_pops", 32'(pop_log.size()), 32'd8);
    chk("s3_dels", 32'(dlog.size()), 32'd8);
    if (pop_log.size() == 8 && dlog.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("s3_order%0d", i), 32'(pop_log[i]), 32'(i % 4));
        chk($sformatf("s3_pcyc%0d", i), 32'(pop_cyc[i]), 32'(pop_cyc[0] + i));
        chk($sformatf("s3_dcyc%0d", i), 32'(dcyc[i]), 32'(dcyc[0] + i));
      end
      for (int i = 0; i < 4; i++) chk($sformatf("s3_word%0d", i), 32'(dlog[i]), 32'(12'h100 + 12'(16 * i)));
    end
    for (int n = 0; n < 4; n++) chk($sformatf("s3_cnt%0d", n), 32'(s_cnt[5*n +: 5]), 32'd2);

    // Backpressure on five words in FIFO1.
    do_reset(2);
    clear_logs();
    words.delete();
    for (int i = 0; i < 5; i++) begin
      fq[1].push_back(12'(12'h3C0 + i));
      words.push_back(12'(12'h3C0 + i));
    end
    ready_in = 1'b0;
    repeat (4) tick();
    held = s_data;
    repeat (8) tick();
    chk("s4_pops", 32'(pop_log.size()), 32'd2);
    chk("s4_valid", 32'(s_valid), 32'd1);
    chk("s4_stable", 32'(s_data), 32'(held));
    drain(40);
    chk("s4_dels", 32'(dlog.size()), 32'd5);
    if (dlog.size() == 5)
      for (int i = 0; i < 5; i++) chk($sformatf("s4_word%0d", i), 32'(dlog[i]), 32'(words[i]));

    // Reset one cycle after a pop drops the in-flight word.
    do_reset(2);
    clear_logs();
    for (int i = 0; i < 3; i++) fq[0].push_back(12'(12'h500 + i));
    for (int i = 0; i < 2; i++) fq[2].push_back(12'(12'h700 + i));
    ready_in = 1'b1;
    for (int i = 0; i < 10 && pop_log.size() == 0; i++) tick();
    chk("s5_pop_seen", 32'(pop_log.size()), 32'd1);
    do_reset(2);
    chk("s5_valid", 32'(s_valid), 32'd0);
    chk("s5_cnt", 32'(s_cnt), 32'd0);
    clear_logs();
    drain(40);
    if (pop_log.size() > 0) chk("s5_restart", 32'(pop_log[0]), 32'd0);
    chk("s5_dels", 32'(dlog.size()), 32'd4);

    // 33 words through port 3: its counter wraps to 1.
    do_reset(2);
    clear_logs();
    for (int i = 0; i < 33; i++) fq[3].push_back(12'(i * 7));
    drain(120);
    chk("s6_dels", 32'(dlog.size()), 32'd33);
    chk("s6_wrap", 32'(s_cnt[19:15]), 32'd1);

    // Randomized traffic and sink stalls.
    do_reset(2);
    clear_logs();
    pushed = 0;
    repeat (400) begin
      for (int n = 0; n < 4; n++)
        if ($urandom_range(0, 3) == 0 && fq[n].size() < 8) begin
          fq[n].push_back(12'($urandom_range(0, 4095)));
          pushed++;
        end
      ready_in = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain(400);
    chk("rand_dels", 32'(dlog.size()), 32'(pushed));
    ok = (s_idle === 1'b1);
    chk("rand_idle", 32'(ok), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
